// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - Ethernet transmit framer: preamble/SFD, payload, zero pad, CRC-32 FCS, IFG
// One output byte register; in_r_TREADY is combinational from the state and that register.
module eth_tx_framer #(
   parameter int MIN_FRAME_BYTES = 60,
   parameter int IFG_BYTES       = 12,
   parameter bit PREAMBLE_ENABLE = 1'b1
) (
   input  logic       ap_clk,
   input  logic       ap_rst_n,
   input  logic [7:0] in_r_TDATA,
   input  logic       in_r_TVALID,
   output logic       in_r_TREADY,
   input  logic       in_r_TLAST,
   output logic [7:0] out_r_TDATA,
   output logic       out_r_TVALID,
   input  logic       out_r_TREADY,
   output logic       out_r_TLAST
);

   typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_DATA, ST_PAD, ST_FCS, ST_IFG} state_t;

   localparam logic [11:0] MIN_W    = 12'(MIN_FRAME_BYTES);
   localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

   state_t      state_q, state_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_last_q, out_last_d;
   logic [31:0] crc_q, crc_d;
   logic [10:0] byte_cnt_q, byte_cnt_d;
   logic [2:0]  pre_cnt_q, pre_cnt_d;
   logic [1:0]  fcs_idx_q, fcs_idx_d;
   logic [15:0] ifg_cnt_q, ifg_cnt_d;

   logic        load;
   logic [11:0] cnt_inc;
   logic [10:0] cnt_sat;
   logic [31:0] fcs_shift;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   assign load         = !out_valid_q || out_r_TREADY;
   assign in_r_TREADY  = (state_q == ST_DATA) && load;
   assign out_r_TDATA  = out_data_q;
   assign out_r_TVALID = out_valid_q;
   assign out_r_TLAST  = out_last_q;

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      crc_d       = crc_q;
      byte_cnt_d  = byte_cnt_q;
      pre_cnt_d   = pre_cnt_q;
      fcs_idx_d   = fcs_idx_q;
      ifg_cnt_d   = ifg_cnt_q;
      cnt_inc     = {1'b0, byte_cnt_q} + 12'd1;
      cnt_sat     = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
      fcs_shift   = (~crc_q) >> {fcs_idx_q, 3'b000};

      // A consumed byte leaves the register empty unless a state below refills it.
      if (load) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (in_r_TVALID) begin
               crc_d      = 32'hFFFFFFFF;
               byte_cnt_d = '0;
               pre_cnt_d  = '0;
               fcs_idx_d  = '0;
               state_d    = PREAMBLE_ENABLE ? ST_PRE : ST_DATA;
            end
         end
         ST_PRE: begin
            if (load) begin
               out_valid_d = 1'b1;
               out_data_d  = (pre_cnt_q == 3'd7) ? 8'hD5 : 8'h55;
               pre_cnt_d   = pre_cnt_q + 3'd1;
               if (pre_cnt_q == 3'd7) state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (load && in_r_TVALID) begin
               out_valid_d = 1'b1;
               out_data_d  = in_r_TDATA;
               crc_d       = crc_byte(crc_q, in_r_TDATA);
               byte_cnt_d  = cnt_sat;
               if (in_r_TLAST) state_d = (cnt_inc < MIN_W) ? ST_PAD : ST_FCS;
            end
         end
         ST_PAD: begin
            if (load) begin
               out_valid_d = 1'b1;
               out_data_d  = 8'h00;
               crc_d       = crc_byte(crc_q, 8'h00);
               byte_cnt_d  = cnt_sat;
               if (cnt_inc >= MIN_W) state_d = ST_FCS;
            end
         end
         ST_FCS: begin
            if (load) begin
               out_valid_d = 1'b1;
               out_data_d  = fcs_shift[7:0];
               out_last_d  = (fcs_idx_q == 2'd3);
               fcs_idx_d   = fcs_idx_q + 2'd1;
               if (fcs_idx_q == 2'd3) begin
                  state_d   = ST_IFG;
                  ifg_cnt_d = '0;
               end
            end
         end
         ST_IFG: begin
            // Gap counting starts only once the final FCS byte has left the register.
            if (!out_valid_q) begin
               if (ifg_cnt_q == IFG_LAST) state_d = ST_IDLE;
               else ifg_cnt_d = ifg_cnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         out_last_q  <= 1'b0;
         crc_q       <= 32'hFFFFFFFF;
         byte_cnt_q  <= '0;
         pre_cnt_q   <= '0;
         fcs_idx_q   <= '0;
         ifg_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         crc_q       <= crc_d;
         byte_cnt_q  <= byte_cnt_d;
         pre_cnt_q   <= pre_cnt_d;
         fcs_idx_q   <= fcs_idx_d;
         ifg_cnt_q   <= ifg_cnt_d;
      end
   end

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - self-checking bench for eth_tx_framer
// Frame-level model: expected wire bytes are built per frame from payload, pad rule and CRC-32.
module tb_eth_tx_framer;

   localparam int MIN = 60;
   localparam int IFG = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst_n, a_ivld, a_irdy, a_ilast, a_ovld, a_ordy, a_olast;
   logic [7:0] a_idata, a_odata;
   logic       b_rst_n, b_ivld, b_irdy, b_ilast, b_ovld, b_ordy, b_olast;
   logic [7:0] b_idata, b_odata;

   eth_tx_framer #(.MIN_FRAME_BYTES(MIN), .IFG_BYTES(IFG), .PREAMBLE_ENABLE(1'b1)) dut_a (
      .ap_clk(clk), .ap_rst_n(a_rst_n),
      .in_r_TDATA(a_idata), .in_r_TVALID(a_ivld), .in_r_TREADY(a_irdy), .in_r_TLAST(a_ilast),
      .out_r_TDATA(a_odata), .out_r_TVALID(a_ovld), .out_r_TREADY(a_ordy), .out_r_TLAST(a_olast));

   eth_tx_framer #(.MIN_FRAME_BYTES(0), .IFG_BYTES(IFG), .PREAMBLE_ENABLE(1'b0)) dut_b (
      .ap_clk(clk), .ap_rst_n(b_rst_n),
      .in_r_TDATA(b_idata), .in_r_TVALID(b_ivld), .in_r_TREADY(b_irdy), .in_r_TLAST(b_ilast),
      .out_r_TDATA(b_odata), .out_r_TVALID(b_ovld), .out_r_TREADY(b_ordy), .out_r_TLAST(b_olast));

   int compared = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] crc32(input logic [7:0] f[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (f[i]) begin
         c = c ^ {24'h0, f[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   logic [8:0] exp_q[$];
   int         exp_len_q[$];
   int         frames_expected = 0;
   int         frames_seen = 0;

   task automatic push_expected(input logic [7:0] d[$]);
      logic [7:0]  f[$];
      logic [31:0] c;
      f = d;
      while (f.size() < MIN) f.push_back(8'h00);
      c = crc32(f);
      for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
      exp_q.push_back({1'b0, 8'hD5});
      foreach (f[i]) exp_q.push_back({1'b0, f[i]});
      for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, 8'(c >> (8 * k))});
      exp_len_q.push_back(8 + f.size() + 4);
      frames_expected++;
   endtask

   // Compare process for dut_a: every handshake, every stall cycle, and the inter-frame gap.
   int         cyc = 0;
   int         last_end = -1;
   int         bytes_in_frame = 0;
   int         rdy_cnt = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       prev_last = 1'b0;

   always @(negedge clk) begin
      logic [8:0] e;
      cyc++;
      if (!a_rst_n) begin
         prev_stall     = 1'b0;
         last_end       = -1;
         bytes_in_frame = 0;
      end else begin
         if (a_irdy) rdy_cnt++;
         if (prev_stall) begin
            check("stall_valid", a_ovld, 1);
            check("stall_data", a_odata, prev_data);
            check("stall_last", a_olast, prev_last);
         end
         if (a_ovld && last_end >= 0) begin
            check("ifg_gap_ok", (cyc - last_end) > IFG, 1);
            last_end = -1;
         end
         if (a_ovld && a_ordy) begin
            bytes_in_frame++;
            if (exp_q.size() == 0) begin
               check("unexpected_byte", a_odata, 9'h1FF);
            end else begin
               e = exp_q.pop_front();
               check("out_data", a_odata, e[7:0]);
               check("out_last", a_olast, e[8]);
            end
            if (a_olast) begin
               frames_seen++;
               last_end = cyc;
               if (exp_len_q.size() != 0) check("frame_len", bytes_in_frame, exp_len_q.pop_front());
               bytes_in_frame = 0;
            end
         end
         prev_stall = a_ovld && !a_ordy;
         prev_data  = a_odata;
         prev_last  = a_olast;
      end
   end

   logic rand_ready = 1'b0;
   initial begin
      a_ordy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         a_ordy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   logic [8:0] got_b[$];
   always @(negedge clk) if (b_rst_n && b_ovld && b_ordy) got_b.push_back({b_olast, b_odata});

   task automatic send_a(input logic [7:0] d[$], input int max_gap);
      int t;
      push_expected(d);
      for (int i = 0; i < d.size(); i++) begin
         if (max_gap > 0 && $urandom_range(0, 2) == 0) begin
            a_ivld = 1'b0;
            repeat ($urandom_range(1, max_gap)) begin
               @(posedge clk);
               #1;
            end
         end
         a_ivld  = 1'b1;
         a_idata = d[i];
         a_ilast = (i == d.size() - 1);
         t = 0;
         forever begin
            @(negedge clk);
            if (a_irdy) break;
            t++;
            if (t > 3000) begin
               check("in_handshake_timeout", 0, 1);
               break;
            end
         end
         @(posedge clk);
         #1;
      end
      a_ivld  = 1'b0;
      a_ilast = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] d[$]);
      int t;
      for (int i = 0; i < d.size(); i++) begin
         b_ivld  = 1'b1;
         b_idata = d[i];
         b_ilast = (i == d.size() - 1);
         t = 0;
         forever begin
            @(negedge clk);
            if (b_irdy) break;
            t++;
            if (t > 500) begin
               check("b_handshake_timeout", 0, 1);
               break;
            end
         end
         @(posedge clk);
         #1;
      end
      b_ivld  = 1'b0;
      b_ilast = 1'b0;
   endtask

   task automatic drain_a();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
      repeat (IFG + 6) @(posedge clk);
      #1;
   endtask

   logic [7:0] pl[$];
   logic [7:0] arp[42] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99,
                           8'hAA, 8'hBB, 8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04,
                           8'h00, 8'h02, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hC0, 8'hA8,
                           8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hC0, 8'hA8,
                           8'h01, 8'h01};
   logic [7:0] b_exp[13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                             8'h26, 8'h39, 8'hF4, 8'hCB};

   initial begin
      a_rst_n = 1'b0; b_rst_n = 1'b0;
      a_ivld = 1'b0; a_ilast = 1'b0; a_idata = 8'h00;
      b_ivld = 1'b0; b_ilast = 1'b0; b_idata = 8'h00; b_ordy = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_a_valid", a_ovld, 0);
      check("rst_a_data", a_odata, 0);
      check("rst_a_last", a_olast, 0);
      check("rst_a_inrdy", a_irdy, 0);
      check("rst_b_valid", b_ovld, 0);
      @(posedge clk);
      #1;
      a_rst_n = 1'b1; b_rst_n = 1'b1;

      // Model pinned against the well-known CRC-32 check value.
      pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      check("model_crc_check", crc32(pl), 32'hCBF43926);

      // No preamble, no padding: "123456789" -> 13 bytes ending in the FCS.
      send_b(pl);
      repeat (40) @(posedge clk);
      #1;
      check("b_byte_count", got_b.size(), 13);
      for (int i = 0; i < 13; i++) begin
         if (i < got_b.size()) begin
            check("b_data", got_b[i][7:0], b_exp[i]);
            check("b_last", got_b[i][8], (i == 12));
         end
      end

      // ARP reply: 42 payload bytes padded to 60; 72 bytes on the wire.
      pl.delete();
      foreach (arp[i]) pl.push_back(arp[i]);
      check("arp_exp_len", 8 + MIN + 4, 72);
      send_a(pl, 0);
      drain_a();

      // 64-byte frame immediately followed by another frame; gap enforced by monitor.
      pl.delete();
      for (int i = 0; i < 64; i++) pl.push_back(8'(i * 7 + 3));
      send_a(pl, 0);
      pl.delete();
      for (int i = 0; i < 10; i++) pl.push_back(8'(8'hA0 + i));
      send_a(pl, 0);
      drain_a();

      // 1-byte frame: exactly one cycle of in_r_TREADY.
      rdy_cnt = 0;
      pl = '{8'hAB};
      send_a(pl, 0);
      drain_a();
      check("one_byte_inrdy_cycles", rdy_cnt, 1);

      // Randomised output backpressure and input gaps.
      rand_ready = 1'b1;
      for (int f = 0; f < 20; f++) begin
         pl.delete();
         for (int i = 0; i < $urandom_range(1, 100); i++) pl.push_back(8'($urandom));
         send_a(pl, 3);
      end
      drain_a();
      rand_ready = 1'b0;
      @(posedge clk);
      #1;

      // Reset pulse while padding aborts the frame; the next frame must be clean.
      pl = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      send_a(pl, 0);
      repeat (2) @(posedge clk);
      #1;
      a_rst_n = 1'b0;
      #1;
      check("abort_valid_low", a_ovld, 0);
      exp_q.delete();
      exp_len_q.delete();
      frames_expected--;
      @(posedge clk);
      #1;
      a_rst_n = 1'b1;
      pl.delete();
      for (int i = 0; i < 20; i++) pl.push_back(8'(8'h5A ^ i));
      send_a(pl, 0);
      drain_a();

      check("all_bytes_out", exp_q.size(), 0);
      check("frame_count", frames_seen, frames_expected);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, required finished");
      $fatal(1, "timeout");
   end

endmodule
